obi_sram_mp: RTL and testbench
==============================

OBI_SRAM_MP -- requirements
Module: obi_sram_mp

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of independent OBI slave ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width in bits; legal values 32 and 64.
REQ-003 SHALL have parameter MEM_SIZE_BYTE, default 32768: total capacity in bytes; power of two.
REQ-004 SHALL have parameter NUM_BANKS, default 4: word-interleaved banks; power of two, at least 1.
REQ-005 SHALL have parameter READ_LATENCY, default 1: cycles from grant to rvalid; range 1..4.
REQ-006 SHALL define BE_W = DATA_WIDTH/8, and BANK_BITS = log2(NUM_BANKS), which is 0 when NUM_BANKS=1.
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk_i  input  1  clock; all state updates on the rising edge.
REQ-009 rst_i  input  1  synchronous active-high reset.
REQ-010 req_i  input  NUM_PORTS  per-port request valid.
REQ-011 we_i  input  NUM_PORTS  per-port write enable (1 = write).
REQ-012 be_i  input  NUM_PORTS*BE_W  per-port byte enables; port p occupies slice p.
REQ-013 addr_i  input  NUM_PORTS*32  per-port byte address.
REQ-014 wdata_i  input  NUM_PORTS*DATA_WIDTH  per-port write data.
REQ-015 gnt_o  output  NUM_PORTS  per-port grant; combinational in the request cycle.
REQ-016 rvalid_o  output  NUM_PORTS  per-port response valid; one-cycle pulse.
REQ-017 rdata_o  output  NUM_PORTS*DATA_WIDTH  per-port read data; valid only while rvalid_o is high.
REQ-018 err_o  output  NUM_PORTS  per-port error flag; valid only while rvalid_o is high.

Function
REQ-019 SHALL map addresses as follows: word = addr >> log2(BE_W); bank = word[BANK_BITS-1:0]; row = word >> BANK_BITS; low addr bits are ignored.
REQ-020 SHALL treat a request as accepted in the cycle in which req_i[p] and gnt_o[p] are both high.
REQ-021 SHALL allow each port to issue a new request every cycle, giving full throughput when no bank conflict occurs.
REQ-022 SHALL grant all ports that target distinct banks in the same cycle.
REQ-023 SHALL arbitrate per bank with round-robin among ports targeting that bank, granting exactly one per cycle.
REQ-024 SHALL update a bank's priority pointer to (granted port + 1) mod NUM_PORTS only on a grant; the pointer holds otherwise.
REQ-025 SHALL keep gnt_o[p] low whenever req_i[p] is low.
REQ-026 SHALL, for a losing port, hold gnt_o low; the requester keeps its request asserted per OBI, and no state changes for it.
REQ-027 SHALL, on an accepted write, update only the bytes whose be_i bit is set, at the next rising edge.
REQ-028 SHALL, on an accepted read, return the row contents sampled at the accept edge; a write accepted in an earlier cycle is visible.
REQ-029 SHALL assert rvalid_o[p] exactly READ_LATENCY cycles after acceptance, for both reads and writes.
REQ-030 SHALL return responses in acceptance order per port, including when one response is issued every cycle.
REQ-031 SHALL drive rdata_o = 0 for write responses, for error responses and whenever rvalid_o is low.
REQ-032 SHALL treat addr >= MEM_SIZE_BYTE as an error: the request is granted, no memory update occurs, and err_o=1 accompanies the rvalid_o pulse.
REQ-033 SHALL still arbitrate an out-of-range request on its computed bank, identically to an in-range request.
REQ-034 SHALL treat be_i = 0 on a write as a legal no-op: the request is granted and gets a normal response.
REQ-035 SHALL implement the memory as a behavioral array with no reset; contents are undefined until written.

Reset
REQ-036 SHALL, while rst_i is high, force gnt_o, rvalid_o and err_o to 0 and rdata_o to 0.
REQ-037 SHALL, on reset, set all bank priority pointers to port 0.
REQ-038 SHALL, on reset, clear all response pipeline stages; in-flight responses are dropped.
REQ-039 SHALL block memory writes in any cycle where rst_i is high.
REQ-040 SHALL preserve memory contents across reset.

Verification
REQ-041 Reset: rst_i high for 2 cycles, with req_i=2'b11 in the second cycle -> gnt_o, rvalid_o and err_o all 0, and no responses after release.
REQ-042 Byte enables: with 0x11223344 stored at 0x10, port 0 writes 0xDEADBEEF with be=4'b0101 -> a subsequent read of 0x10 returns 0x11AD33EF.
REQ-043 Conflict: ports 0 and 1 both read 0x0 in the same cycle after reset -> port 0 is granted that cycle and port 1 the next; a repeat of the simultaneous request grants port 0 first again.
REQ-044 Parallel access: port 0 reads 0x0 and port 1 reads 0x4 (NUM_BANKS=4) -> both granted in the same cycle, with both rvalid_o pulses READ_LATENCY cycles later.
REQ-045 Pipelining: READ_LATENCY=2, port 0 reads 0x0, 0x4, 0x8, 0xC on consecutive cycles -> rvalid_o[0] is high for 4 consecutive cycles starting 2 cycles after the first grant, with data in issue order.
REQ-046 Error: port 1 writes 0x8000 (MEM_SIZE_BYTE=32768) -> granted, err_o[1]=1 with rvalid_o[1], rdata_o=0, and a read of 0x0 is unchanged.

Source files
------------

// File: rtl/obi_sram_mp_if.sv
// OBI slave-side bundle for the multi-port SRAM: request/grant plus response channel.
// Per-port fields are packed side by side with port p in slice p.
interface obi_sram_mp_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*BE_W-1:0]       be_i;
    logic [NUM_PORTS*32-1:0]         addr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_PORTS-1:0]            err_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_sram_mp.sv
// Multi-port banked SRAM: per-bank round-robin, combinational grant, response READ_LATENCY cycles after accept.
// Backpressure: a losing port sees gnt_o low and must hold its request; responses cannot be stalled.
module obi_sram_mp #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_SIZE_BYTE = 32768,
    parameter int NUM_BANKS     = 4,
    parameter int READ_LATENCY  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    obi_sram_mp_if.slave  bus
);
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(BE_W);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROWS      = MEM_SIZE_BYTE / (BE_W * NUM_BANKS);
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];

    logic [NUM_PORTS-1:0][BANK_W-1:0] bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]  row;
    logic [NUM_PORTS-1:0]             oor;
    logic [NUM_PORTS-1:0]             gnt;
    logic [NUM_PORTS-1:0]             acc_wr;

    logic [NUM_BANKS-1:0][PORT_W-1:0] ptr_q, ptr_d;

    logic [READ_LATENCY-1:0][NUM_PORTS-1:0]                 vld_q, vld_d;
    logic [READ_LATENCY-1:0][NUM_PORTS-1:0]                 err_q, err_d;
    logic [READ_LATENCY-1:0][NUM_PORTS-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        logic [31:0] word;
        word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            word    = bus.addr_i[p*32 +: 32] >> OFF_BITS;
            bank[p] = BANK_W'(word & 32'(NUM_BANKS - 1));
            row[p]  = ROW_W'(word >> BANK_BITS);
            oor[p]  = bus.addr_i[p*32 +: 32] >= 32'(MEM_SIZE_BYTE);
        end
    end

    // Each bank scans ports starting at its pointer; out-of-range requests compete like any other.
    always_comb begin
        logic found;
        int   p;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        p     = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                p = (int'(ptr_q[b]) + i) % NUM_PORTS;
                if (!found && bus.req_i[p] && int'(bank[p]) == b) begin
                    gnt[p]   = 1'b1;
                    found    = 1'b1;
                    ptr_d[b] = PORT_W'((p + 1) % NUM_PORTS);
                end
            end
        end
        if (rst_i) begin
            gnt = '0;
        end
    end

    // Stage 0 samples the array before this edge's writes land, so reads see only earlier writes.
    always_comb begin
        vld_d = '0;
        err_d = '0;
        dat_d = '0;
        vld_d[0] = gnt;
        err_d[0] = gnt & oor;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p] && !bus.we_i[p] && !oor[p]) begin
                dat_d[0][p] = mem_q[bank[p]][row[p]];
            end
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            err_d[s] = err_q[s-1];
            dat_d[s] = dat_q[s-1];
        end
        acc_wr = gnt & bus.we_i & ~oor & {NUM_PORTS{~rst_i}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc_wr[p]) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bus.be_i[p*BE_W + k]) begin
                        mem_q[bank[p]][row[p]][8*k +: 8] <= bus.wdata_i[p*DATA_WIDTH + 8*k +: 8];
                    end
                end
            end
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rst_i ? '0 : vld_q[READ_LATENCY-1];
    assign bus.err_o    = rst_i ? '0 : err_q[READ_LATENCY-1];
    assign bus.rdata_o  = rst_i ? '0 : dat_q[READ_LATENCY-1];
endmodule

// File: tb/tb_obi_sram_mp.sv
// Bench for obi_sram_mp: byte-addressed reference model with per-port response queues,
// checked every cycle, plus directed literal expectations.
module tb_obi_sram_mp;
    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int NB    = 4;
    localparam int LAT   = 2;
    localparam int MEMSZ = 32768;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    obi_sram_mp_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    obi_sram_mp #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .MEM_SIZE_BYTE(MEMSZ),
        .NUM_BANKS(NB), .READ_LATENCY(LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] dat;
        logic        err;
        bit          known;
    } rsp_t;

    logic [7:0]  mem_b [int];
    int          ptr [NB];
    rsp_t        rq [NP][$];
    logic [31:0] last_dat [NP];
    logic        last_err [NP];
    int          rv_count = 0;
    int          hist_cyc [$];
    logic [31:0] hist_dat [$];

    function automatic logic [31:0] addr_of(input int p);
        return bus.addr_i[p*32 +: 32];
    endfunction

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 2) % NB);
    endfunction

    always @(negedge clk) begin : cmp
        logic [NP-1:0] eg;
        rsp_t          r;
        logic [31:0]   a;
        int            b, dp, dq, wa;
        for (int p = 0; p < NP; p++) begin
            if (bus.rvalid_o[p]) begin
                rv_count++;
                last_dat[p] = bus.rdata_o[p*DW +: DW];
                last_err[p] = bus.err_o[p];
                if (p == 0) begin
                    hist_cyc.push_back(cyc);
                    hist_dat.push_back(bus.rdata_o[DW-1:0]);
                end
            end
        end
        if (rst_i) begin
            chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
            chk("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
            chk("rst_err", 64'(bus.err_o), 64'(0));
            chk("rst_rdata", 64'(bus.rdata_o), 64'(0));
            for (int p = 0; p < NP; p++) rq[p].delete();
            for (int k = 0; k < NB; k++) ptr[k] = 0;
        end else begin
            // A requester wins unless a same-bank requester sits closer after the bank pointer.
            eg = '0;
            for (int p = 0; p < NP; p++) begin
                if (bus.req_i[p]) begin
                    b  = bank_of(addr_of(p));
                    dp = (p - ptr[b] + NP) % NP;
                    eg[p] = 1'b1;
                    for (int q = 0; q < NP; q++) begin
                        if (q != p && bus.req_i[q] && bank_of(addr_of(q)) == b) begin
                            dq = (q - ptr[b] + NP) % NP;
                            if (dq < dp) eg[p] = 1'b0;
                        end
                    end
                end
            end
            chk("gnt", 64'(bus.gnt_o), 64'(eg));

            for (int p = 0; p < NP; p++) begin
                if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
                    r = rq[p].pop_front();
                    chk($sformatf("rvalid%0d", p), 64'(bus.rvalid_o[p]), 64'(1));
                    chk($sformatf("err%0d", p), 64'(bus.err_o[p]), 64'(r.err));
                    if (r.known) chk($sformatf("rdata%0d", p), 64'(bus.rdata_o[p*DW +: DW]), 64'(r.dat));
                end else begin
                    chk($sformatf("rvalid_idle%0d", p), 64'(bus.rvalid_o[p]), 64'(0));
                    chk($sformatf("rdata_idle%0d", p), 64'(bus.rdata_o[p*DW +: DW]), 64'(0));
                end
            end

            for (int p = 0; p < NP; p++) begin
                if (eg[p]) begin
                    a       = addr_of(p);
                    wa      = int'(a & ~32'h3);
                    r.due   = cyc + LAT;
                    r.err   = (a >= 32'(MEMSZ));
                    r.dat   = '0;
                    r.known = 1'b1;
                    if (!r.err && !bus.we_i[p]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (mem_b.exists(wa + k)) r.dat[8*k +: 8] = mem_b[wa + k];
                            else r.known = 1'b0;
                        end
                    end
                    rq[p].push_back(r);
                    ptr[bank_of(a)] = (p + 1) % NP;
                end
            end
            for (int p = 0; p < NP; p++) begin
                a  = addr_of(p);
                wa = int'(a & ~32'h3);
                if (eg[p] && bus.we_i[p] && a < 32'(MEMSZ)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.be_i[p*4 + k]) mem_b[wa + k] = bus.wdata_i[p*DW + 8*k +: 8];
                    end
                end
            end
        end
    end

    task automatic set_port(input int p, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        bus.we_i[p]           = we;
        bus.addr_i[p*32 +: 32] = a;
        bus.wdata_i[p*DW +: DW] = d;
        bus.be_i[p*4 +: 4]     = be;
    endtask

    // Holds each request until granted; reports the cycle offset of each grant.
    task automatic go(input logic [NP-1:0] mask, output int g0, output int g1);
        logic [NP-1:0] pend, seen;
        g0 = -1;
        g1 = -1;
        pend = mask;
        bus.req_i = mask;
        for (int t = 0; t < 16 && pend != 0; t++) begin
            @(negedge clk);
            seen = bus.gnt_o & pend;
            if (seen[0]) g0 = t;
            if (seen[1]) g1 = t;
            @(posedge clk);
            #1;
            pend = pend & ~seen;
            bus.req_i = pend;
        end
        if (pend != 0) begin
            n_chk++;
            $display("FAIL go_timeout: pending %b, expected none", pend);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int g0, g1, g, snap;
        logic [31:0] pv [4];
        pv[0] = 32'hA0A0_0000;
        pv[1] = 32'hB1B1_0004;
        pv[2] = 32'hC2C2_0008;
        pv[3] = 32'hD3D3_000C;

        rst_i       = 1'b1;
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.be_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;

        // Reset with both ports requesting in the second reset cycle
        @(posedge clk);
        #1;
        bus.req_i = 2'b11;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        bus.req_i = '0;
        idle(4);
        chk("rst_no_rsp", 64'(rv_count), 64'(0));

        // Fill memory; writes to distinct banks proceed together
        set_port(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF);
        go(2'b01, g0, g1);
        set_port(0, 1'b1, 32'h0, pv[0], 4'hF);
        set_port(1, 1'b1, 32'h4, pv[1], 4'hF);
        go(2'b11, g0, g1);
        chk("par_wr_g0", 64'(g0), 64'(0));
        chk("par_wr_g1", 64'(g1), 64'(0));
        set_port(0, 1'b1, 32'h8, pv[2], 4'hF);
        set_port(1, 1'b1, 32'hC, pv[3], 4'hF);
        go(2'b11, g0, g1);
        idle(LAT + 1);

        // Parallel reads on banks 0 and 1
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h4, 32'h0, 4'h0);
        go(2'b11, g0, g1);
        chk("par_rd_g0", 64'(g0), 64'(0));
        chk("par_rd_g1", 64'(g1), 64'(0));
        idle(LAT + 1);
        chk("par_rd_d0", 64'(last_dat[0]), 64'h0000_0000_A0A0_0000);
        chk("par_rd_d1", 64'(last_dat[1]), 64'h0000_0000_B1B1_0004);

        // Partial byte-enable write then read back
        set_port(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0101);
        go(2'b01, g0, g1);
        set_port(0, 1'b0, 32'h10, 32'h0, 4'h0);
        go(2'b01, g0, g1);
        idle(LAT + 1);
        chk("be_merge", 64'(last_dat[0]), 64'h0000_0000_11AD_33EF);

        // Reset while a read is in flight: its response must vanish
        snap = rv_count;
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        go(2'b01, g0, g1);
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        idle(4);
        chk("drop_inflight", 64'(rv_count), 64'(snap));

        // Same-bank conflict from reset pointers, twice
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0, 32'h0, 4'h0);
        go(2'b11, g0, g1);
        chk("conf1_g0", 64'(g0), 64'(0));
        chk("conf1_g1", 64'(g1), 64'(1));
        go(2'b11, g0, g1);
        chk("conf2_g0", 64'(g0), 64'(0));
        chk("conf2_g1", 64'(g1), 64'(1));
        idle(LAT + 1);
        chk("mem_kept_rst", 64'(last_dat[1]), 64'h0000_0000_A0A0_0000);

        // Back-to-back reads on port 0
        hist_cyc.delete();
        hist_dat.delete();
        g = -1;
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b0, 32'(i * 4), 32'h0, 4'h0);
            bus.req_i = 2'b01;
            @(negedge clk);
            chk($sformatf("pipe_gnt%0d", i), 64'(bus.gnt_o[0]), 64'(1));
            if (i == 0) g = cyc;
            @(posedge clk);
            #1;
        end
        bus.req_i = '0;
        idle(LAT + 2);
        chk("pipe_cnt", 64'(hist_cyc.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < hist_cyc.size()) begin
                chk($sformatf("pipe_cyc%0d", i), 64'(hist_cyc[i]), 64'(g + LAT + i));
                chk($sformatf("pipe_dat%0d", i), 64'(hist_dat[i]), 64'(pv[i]));
            end
        end

        // Out-of-range write on port 1, then confirm aliasing row untouched
        set_port(1, 1'b1, 32'h8000, 32'hFFFF_FFFF, 4'hF);
        go(2'b10, g0, g1);
        chk("oor_g1", 64'(g1), 64'(0));
        idle(LAT + 1);
        chk("oor_err", 64'(last_err[1]), 64'(1));
        chk("oor_rdata", 64'(last_dat[1]), 64'(0));

        // Zero byte-enable write is a no-op
        set_port(0, 1'b1, 32'h0, 32'h1234_5678, 4'h0);
        go(2'b01, g0, g1);
        chk("be0_g0", 64'(g0), 64'(0));
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        go(2'b01, g0, g1);
        idle(LAT + 1);
        chk("mem_unchanged", 64'(last_dat[0]), 64'h0000_0000_A0A0_0000);
        chk("rd_err_clear", 64'(last_err[0]), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
